// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root unit.
//   state_t : handshake FSM states.
//   qw_of() : result width for a given radical width, (width+1)/2.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int qw_of(input int width);
    return (width + 1) / 2;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration, purely combinational.
// Brings the next two radical bits into the partial remainder, then tries
// to subtract (q<<2)|1. A successful trial appends a 1 to the partial root.
module sqrt_step #(
  parameter int  QW = 8,
  localparam int RW = QW + 1
) (
  input  logic [RW:0]   r_in,
  input  logic [QW-1:0] q_in,
  input  logic [1:0]    pair,
  output logic [RW:0]   r_out,
  output logic [QW-1:0] q_out
);

  logic [RW+2:0] r_sh;
  logic [RW+2:0] trial;
  logic [RW+2:0] diff;
  logic [QW:0]   q_sh;
  logic          ge;
  logic          unused_hi;

  // Trial subtraction; the kept remainder always fits RW+1 bits, so the two
  // extra MSBs of the widened arithmetic are discarded.
  always_comb begin
    r_sh  = {r_in, pair};
    trial = (RW + 3)'({q_in, 2'b01});
    ge    = (r_sh >= trial);
    diff  = r_sh - trial;
    r_out = ge ? diff[RW:0] : r_sh[RW:0];
    q_sh  = {q_in, ge};
    q_out = q_sh[QW-1:0];
  end

  assign unused_hi = ^{diff[RW+2:RW+1], r_sh[RW+2:RW+1], q_sh[QW]};

endmodule

// File: rtl/sqrt_iter_hs.sv
// Iterative handshaked integer square root: q = floor(sqrt(radical)),
// remainder = radical - q*q. STEPS result bits are resolved per enabled
// clock via a chain of sqrt_step instances.
// Optional build macro: SQRT_ROUND_EN adds a registered q_round output
// (q rounded to nearest, saturating at all-ones).
module sqrt_iter_hs
  import sqrt_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  STEPS = 1,
  parameter int  TAG_W = 4,
  localparam int QW    = qw_of(WIDTH),
  localparam int RW    = QW + 1,
  localparam int ITERS = QW / STEPS
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] radical,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    q,
  output logic [RW-1:0]    remainder,
  output logic [TAG_W-1:0] out_tag,
`ifdef SQRT_ROUND_EN
  output logic [QW-1:0]    q_round,
`endif
  output logic             busy
);

  localparam int CW = $clog2(ITERS + 1);

  if (WIDTH < 2 || STEPS < 1 || (QW % STEPS) != 0) begin : g_bad_cfg
    $error("sqrt_iter_hs: WIDTH must be >= 2 and STEPS must divide (WIDTH+1)/2");
  end

  state_t           state;
  state_t           state_nx;
  logic [2*QW-1:0]  rad_sh;
  logic [RW:0]      r_acc;
  logic [QW-1:0]    q_acc;
  logic [CW-1:0]    cnt;
  logic [TAG_W-1:0] tag_hold;
  logic             in_hs;
  logic             last;

  // Iteration chain: element 0 is the registered partial result, element
  // STEPS is what gets written back after one enabled cycle.
  logic [RW:0]      r_ch [STEPS+1];
  logic [QW-1:0]    q_ch [STEPS+1];

  assign r_ch[0] = r_acc;
  assign q_ch[0] = q_acc;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    sqrt_step #(.QW(QW)) u_step (
      .r_in  (r_ch[i]),
      .q_in  (q_ch[i]),
      .pair  (rad_sh[2*QW-1-2*i -: 2]),
      .r_out (r_ch[i+1]),
      .q_out (q_ch[i+1])
    );
  end

  assign in_hs     = in_valid && in_ready && ena;
  assign last      = (cnt == CW'(1));
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);

  // State register; every transition is already qualified by ena.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of the order of always blocks.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and input-ready decode; a DONE slot accepts the next operand
  // in the same cycle its result is taken.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && ena) state_nx = BUSY;
      end
      BUSY: begin
        if (ena && last) state_nx = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (ena && out_ready) state_nx = in_valid ? BUSY : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef SQRT_ROUND_EN
  logic [QW-1:0] q_round_nx;

  // Round to nearest: sqrt(radical) >= q + 0.5 exactly when remainder > q.
  always_comb begin
    q_round_nx = q_ch[STEPS];
    if ((r_ch[STEPS][RW-1:0] > RW'(q_ch[STEPS])) && !(&q_ch[STEPS]))
      q_round_nx = q_ch[STEPS] + QW'(1);
  end
`endif

  // Operand capture, per-cycle iteration and result registration.
  // NOTE: the radical shadow and partial results are ordinary flops, so they
  // are cleared on aclr like the visible outputs; an abort leaves no residue.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rad_sh    <= '0;
      r_acc     <= '0;
      q_acc     <= '0;
      cnt       <= '0;
      tag_hold  <= '0;
      q         <= '0;
      remainder <= '0;
      out_tag   <= '0;
`ifdef SQRT_ROUND_EN
      q_round   <= '0;
`endif
    end else if (ena) begin
      if (in_hs) begin
        rad_sh   <= (2*QW)'(radical);
        tag_hold <= in_tag;
        r_acc    <= '0;
        q_acc    <= '0;
        cnt      <= CW'(ITERS);
      end else if (state == BUSY) begin
        rad_sh <= rad_sh << (2*STEPS);
        r_acc  <= r_ch[STEPS];
        q_acc  <= q_ch[STEPS];
        cnt    <= cnt - CW'(1);
        if (last) begin
          q         <= q_ch[STEPS];
          remainder <= r_ch[STEPS][RW-1:0];
          out_tag   <= tag_hold;
`ifdef SQRT_ROUND_EN
          q_round   <= q_round_nx;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sqrt_iter_hs.sv
// Scoreboard bench for sqrt_iter_hs. Three instances:
//   dut 0: WIDTH=16 STEPS=1 (main, backpressure, enable, abort)
//   dut 1: WIDTH=9  STEPS=1 (odd width)
//   dut 2: WIDTH=16 STEPS=2 (two bits per cycle, back-to-back throughput)
// Build with SQRT_ROUND_EN defined to also check q_round.
module tb_sqrt_iter_hs;

  localparam int QA = sqrt_pkg::qw_of(16);
  localparam int QB = sqrt_pkg::qw_of(9);

  typedef struct {
    int          dut;
    logic [15:0] q;
    logic [15:0] r;
    logic [15:0] qr;
    logic [3:0]  tag;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic        clk = 1'b0;
  logic        aclr;
  logic        ena;
  logic        iv   [3];
  logic [15:0] rad  [3];
  logic [3:0]  itag [3];
  logic        ordy [3];

  logic        ir   [3];
  logic        ov   [3];
  logic        bsy  [3];
  logic [15:0] qo   [3];
  logic [15:0] ro   [3];
  logic [3:0]  otag [3];

  logic [QA-1:0] q_a;
  logic [QA:0]   r_a;
  logic [QB-1:0] q_b;
  logic [QB:0]   r_b;
  logic [QA-1:0] q_c;
  logic [QA:0]   r_c;

  assign qo[0] = 16'(q_a);
  assign ro[0] = 16'(r_a);
  assign qo[1] = 16'(q_b);
  assign ro[1] = 16'(r_b);
  assign qo[2] = 16'(q_c);
  assign ro[2] = 16'(r_c);

`ifdef SQRT_ROUND_EN
  logic [15:0]   qro [3];
  logic [QA-1:0] qr_a;
  logic [QB-1:0] qr_b;
  logic [QA-1:0] qr_c;
  assign qro[0] = 16'(qr_a);
  assign qro[1] = 16'(qr_b);
  assign qro[2] = 16'(qr_c);
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sqrt_iter_hs #(.WIDTH(16), .STEPS(1), .TAG_W(4)) u_dut_a (
    .clk       (clk),
    .aclr      (aclr),
    .ena       (ena),
    .in_valid  (iv[0]),
    .in_ready  (ir[0]),
    .radical   (rad[0]),
    .in_tag    (itag[0]),
    .out_valid (ov[0]),
    .out_ready (ordy[0]),
    .q         (q_a),
    .remainder (r_a),
    .out_tag   (otag[0]),
`ifdef SQRT_ROUND_EN
    .q_round   (qr_a),
`endif
    .busy      (bsy[0])
  );

  sqrt_iter_hs #(.WIDTH(9), .STEPS(1), .TAG_W(4)) u_dut_b (
    .clk       (clk),
    .aclr      (aclr),
    .ena       (ena),
    .in_valid  (iv[1]),
    .in_ready  (ir[1]),
    .radical   (rad[1][8:0]),
    .in_tag    (itag[1]),
    .out_valid (ov[1]),
    .out_ready (ordy[1]),
    .q         (q_b),
    .remainder (r_b),
    .out_tag   (otag[1]),
`ifdef SQRT_ROUND_EN
    .q_round   (qr_b),
`endif
    .busy      (bsy[1])
  );

  sqrt_iter_hs #(.WIDTH(16), .STEPS(2), .TAG_W(4)) u_dut_c (
    .clk       (clk),
    .aclr      (aclr),
    .ena       (ena),
    .in_valid  (iv[2]),
    .in_ready  (ir[2]),
    .radical   (rad[2]),
    .in_tag    (itag[2]),
    .out_valid (ov[2]),
    .out_ready (ordy[2]),
    .q         (q_c),
    .remainder (r_c),
    .out_tag   (otag[2]),
`ifdef SQRT_ROUND_EN
    .q_round   (qr_c),
`endif
    .busy      (bsy[2])
  );

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d got=%0d want=%0d (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  // Present one operand, wait (bounded) for acceptance and push the expected
  // result. in_valid is left high so consecutive calls stream back-to-back.
  task automatic send(input int d, input logic [15:0] r, input logic [3:0] tg,
                      input logic [15:0] eq, input logic [15:0] er, input logic [15:0] eqr,
                      input int lat, output int acc);
    exp_t e;
    int   n;
    @(negedge clk);
    iv[d]   = 1'b1;
    rad[d]  = r;
    itag[d] = tg;
    n = 0;
    while (!(ir[d] && ena) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut=%0d radical=%0d", d, r);
      acc = -1;
    end else begin
      acc   = cyc + 1;
      e.dut = d;
      e.q   = eq;
      e.r   = er;
      e.qr  = eqr;
      e.tag = tg;
      e.due = acc + lat;
      sb.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    iv[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: latency on each rising out_valid, values on each output
  // handshake, and hold-stability while the consumer stalls.
  logic        ovp [3] = '{1'b0, 1'b0, 1'b0};
  logic        hsp [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] q_h [3];
  logic [15:0] r_h [3];
  logic [3:0]  t_h [3];

  always @(negedge clk) begin
    #1;
    if (!aclr) begin
      for (int d = 0; d < 3; d++) begin
        logic hs;
        hs = ov[d] && ordy[d] && ena;
        if (ov[d] && !ovp[d]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result dut=%0d q=%0d", d, qo[d]);
          end else begin
            check("dut_index", d, d, sb[0].dut);
            check("latency", d, cyc, sb[0].due);
          end
        end
        if (ov[d] && ovp[d] && !hsp[d]) begin
          check("hold_q", d, qo[d], q_h[d]);
          check("hold_rem", d, ro[d], r_h[d]);
          check("hold_tag", d, otag[d], t_h[d]);
        end
        if (ov[d] && !ordy[d]) check("in_ready_stall", d, ir[d], 0);
        if (hs && sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("q", d, qo[d], e.q);
          check("remainder", d, ro[d], e.r);
          check("out_tag", d, otag[d], e.tag);
`ifdef SQRT_ROUND_EN
          check("q_round", d, qro[d], e.qr);
`endif
        end
        ovp[d] = ov[d];
        hsp[d] = hs;
        q_h[d] = qo[d];
        r_h[d] = ro[d];
        t_h[d] = otag[d];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc_prev;
    int n;
    aclr = 1'b1;
    ena  = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d]   = 1'b0;
      rad[d]  = '0;
      itag[d] = '0;
      ordy[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    aclr = 1'b0;
    @(negedge clk);
    #1;
    check("rst_q", 0, qo[0], 0);
    check("rst_rem", 0, ro[0], 0);
    check("rst_tag", 0, otag[0], 0);
    check("rst_out_valid", 0, ov[0], 0);
    check("rst_busy", 0, bsy[0], 0);
    check("rst_in_ready", 0, ir[0], 1);

    // Basic vectors, streamed, consumer always ready.
    send(0, 16'd0,     4'd1, 16'd0,   16'd0,   16'd0,   8, acc);
    send(0, 16'd144,   4'd2, 16'd12,  16'd0,   16'd12,  8, acc);
    send(0, 16'd200,   4'd3, 16'd14,  16'd4,   16'd14,  8, acc);
    send(0, 16'd65535, 4'd4, 16'd255, 16'd510, 16'd255, 8, acc);
    idle(0);
    drain();

    // Backpressure: hold the result for 10 cycles.
    ordy[0] = 1'b0;
    send(0, 16'd81, 4'd5, 16'd9, 16'd0, 16'd9, 8, acc);
    idle(0);
    n = 0;
    while (!ov[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL bp_valid_timeout dut=0");
    end
    repeat (10) @(negedge clk);
    ordy[0] = 1'b1;
    drain();

    // Clock enable low for 3 cycles mid-BUSY: latency 8 -> 11.
    send(0, 16'd144, 4'd6, 16'd12, 16'd0, 16'd12, 11, acc);
    idle(0);
    @(negedge clk);
    ena = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    drain();

    // Abort 3 cycles into BUSY; the pending result must never appear.
    send(0, 16'd65535, 4'd7, 16'd255, 16'd510, 16'd255, 8, acc);
    idle(0);
    repeat (3) @(posedge clk);
    #2;
    aclr = 1'b1;
    #1;
    check("abort_q", 0, qo[0], 0);
    check("abort_rem", 0, ro[0], 0);
    check("abort_tag", 0, otag[0], 0);
    check("abort_out_valid", 0, ov[0], 0);
    check("abort_busy", 0, bsy[0], 0);
    sb.delete();
    @(negedge clk);
    aclr = 1'b0;
    @(negedge clk);
    #1;
    check("abort_in_ready", 0, ir[0], 1);
    send(0, 16'd81, 4'd8, 16'd9, 16'd0, 16'd9, 8, acc);
    idle(0);
    drain();

`ifdef SQRT_ROUND_EN
    send(0, 16'd210,   4'd9,  16'd14,  16'd14,  16'd14,  8, acc);
    send(0, 16'd211,   4'd10, 16'd14,  16'd15,  16'd15,  8, acc);
    send(0, 16'd65535, 4'd11, 16'd255, 16'd510, 16'd255, 8, acc);
    idle(0);
    drain();
`endif

    // Odd radical width: radical is zero-extended to 10 bits, 5 iterations.
    send(1, 16'd511, 4'd1, 16'd22, 16'd27, 16'd23, 5, acc);
    send(1, 16'd1,   4'd2, 16'd1,  16'd0,  16'd1,  5, acc);
    idle(1);
    drain();

    // Two bits per cycle: latency 4, one accept every 5 cycles when streaming.
    send(2, 16'd200, 4'd2, 16'd14, 16'd4, 16'd14, 4, acc);
    acc_prev = acc;
    send(2, 16'd144, 4'd3, 16'd12, 16'd0, 16'd12, 4, acc);
    check("accept_gap", 2, acc - acc_prev, 5);
    acc_prev = acc;
    send(2, 16'd65535, 4'd4, 16'd255, 16'd510, 16'd255, 4, acc);
    check("accept_gap", 2, acc - acc_prev, 5);
    acc_prev = acc;
    send(2, 16'd0, 4'd5, 16'd0, 16'd0, 16'd0, 4, acc);
    check("accept_gap", 2, acc - acc_prev, 5);
    idle(2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
